// File: rtl/fcmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fcmp_pipe
//  Description : Pipelined IEEE-754 comparator (EQ / LT / LE / UNORD) with
//                NaN and signed-zero handling, a pass-through tag and a
//                global-stall valid/ready pipeline of STAGES registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module fcmp_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     x2,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             y,
  output logic             nan,
  output logic             snan,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] C_OP_EQ    = 2'b00;
  localparam logic [1:0] C_OP_LT    = 2'b01;
  localparam logic [1:0] C_OP_LE    = 2'b10;
  localparam logic [1:0] C_OP_UNORD = 2'b11;

  // Whole pipeline moves together; it only stalls when the output is full
  // and the consumer is not taking it.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Operand classification and the ordered relation.
  logic w_a_nan, w_b_nan, w_a_zero, w_b_zero;
  logic w_mag_eq, w_mag_lt, w_both_zero;
  logic w_nan, w_snan, w_eq, w_lt;

  // Combinational classification of the incoming operand pair.
  always_comb begin
    w_a_nan     = (&x1[W-2:MAN_W]) && (|x1[MAN_W-1:0]);
    w_b_nan     = (&x2[W-2:MAN_W]) && (|x2[MAN_W-1:0]);
    w_a_zero    = ~|x1[W-2:0];
    w_b_zero    = ~|x2[W-2:0];
    w_mag_eq    = (x1[W-2:0] == x2[W-2:0]);
    w_mag_lt    = (x1[W-2:0] <  x2[W-2:0]);
    w_both_zero = w_a_zero && w_b_zero;
    w_nan       = w_a_nan || w_b_nan;
    // Signalling NaN: quiet bit (mantissa MSB) clear.
    w_snan      = (w_a_nan && !x1[MAN_W-1]) || (w_b_nan && !x2[MAN_W-1]);
    w_eq        = w_both_zero || ((x1[W-1] == x2[W-1]) && w_mag_eq);
    w_lt        = 1'b0;
    if (!w_both_zero) begin
      if (x1[W-1] != x2[W-1])
        w_lt = x1[W-1];                  // negative A is below positive B
      else if (x1[W-1])
        w_lt = !w_mag_lt && !w_mag_eq;   // both negative: larger magnitude is smaller
      else
        w_lt = w_mag_lt;
    end
    // Unordered operands never satisfy an ordered relation.
    if (w_nan) begin
      w_eq = 1'b0;
      w_lt = 1'b0;
    end
  end

  // Final op decode from the classified relation.
  function automatic logic f_result(input logic [1:0] f_op, input logic f_eq,
                                    input logic f_lt, input logic f_nan);
    logic r;
    case (f_op)
      C_OP_EQ: r = f_eq;
      C_OP_LT: r = f_lt;
      C_OP_LE: r = f_lt || f_eq;
      C_OP_UNORD: r = f_nan;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  if (STAGES == 1) begin : g_one
    // Single register stage: classification and result captured together.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        out_valid <= 1'b0;
        y         <= 1'b0;
        nan       <= 1'b0;
        snan      <= 1'b0;
        tag_out   <= '0;
      end else if (w_adv) begin
        out_valid <= in_valid;
        y         <= f_result(op, w_eq, w_lt, w_nan);
        nan       <= w_nan;
        snan      <= w_snan;
        tag_out   <= tag_in;
      end
    end
  end else begin : g_multi
    // Stage 1 .. STAGES-1 hold the classified relation; the last stage
    // decodes the op into y.
    logic             r_vld  [STAGES-1];
    logic [1:0]       r_op   [STAGES-1];
    logic             r_eq   [STAGES-1];
    logic             r_lt   [STAGES-1];
    logic             r_nan  [STAGES-1];
    logic             r_snan [STAGES-1];
    logic [TAG_W-1:0] r_tag  [STAGES-1];

    // Classification stage followed by pure delay stages.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int i = 0; i < STAGES-1; i++) begin
          r_vld[i]  <= 1'b0;
          r_op[i]   <= '0;
          r_eq[i]   <= 1'b0;
          r_lt[i]   <= 1'b0;
          r_nan[i]  <= 1'b0;
          r_snan[i] <= 1'b0;
          r_tag[i]  <= '0;
        end
      end else if (w_adv) begin
        r_vld[0]  <= in_valid;
        r_op[0]   <= op;
        r_eq[0]   <= w_eq;
        r_lt[0]   <= w_lt;
        r_nan[0]  <= w_nan;
        r_snan[0] <= w_snan;
        r_tag[0]  <= tag_in;
        for (int i = 1; i < STAGES-1; i++) begin
          r_vld[i]  <= r_vld[i-1];
          r_op[i]   <= r_op[i-1];
          r_eq[i]   <= r_eq[i-1];
          r_lt[i]   <= r_lt[i-1];
          r_nan[i]  <= r_nan[i-1];
          r_snan[i] <= r_snan[i-1];
          r_tag[i]  <= r_tag[i-1];
        end
      end
    end

    // Output stage: op decode and result registers.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        out_valid <= 1'b0;
        y         <= 1'b0;
        nan       <= 1'b0;
        snan      <= 1'b0;
        tag_out   <= '0;
      end else if (w_adv) begin
        out_valid <= r_vld[STAGES-2];
        y         <= f_result(r_op[STAGES-2], r_eq[STAGES-2], r_lt[STAGES-2],
                              r_nan[STAGES-2]);
        nan       <= r_nan[STAGES-2];
        snan      <= r_snan[STAGES-2];
        tag_out   <= r_tag[STAGES-2];
      end
    end
  end

endmodule
`default_nettype wire
